// File: rtl/us_timming_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// us_timming_pkg : shared constants, entry layout and FSM encoding for the framer
// Rev 1.0
// ----------------------------------------------------------------------------
package us_timming_pkg;

   localparam logic [15:0] c_sync_word_default = 16'hEB90;
   localparam logic [15:0] c_tail_word_default = 16'h5AA5;

   localparam int c_data_w       = 128;
   localparam int c_beat_w       = 32;
   localparam int c_entry_w      = 130;
   localparam int c_eof_bit      = 129;
   localparam int c_has_data_bit = 128;

   localparam int          c_beats_per_word = 4;
   localparam logic [1:0]  c_last_beat      = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEAD    = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_NEXT    = 3'd3,
      ST_TAIL0   = 3'd4,
      ST_TAIL1   = 3'd5
   } state_t;

   // Beat 0 is the most significant 32-bit word of the timing word.
   function automatic logic [c_beat_w-1:0] beat_sel(input logic [c_data_w-1:0] data,
                                                     input logic [1:0]          idx);
      logic [c_beat_w-1:0] r;
      case (idx)
         2'd0:    r = data[127:96];
         2'd1:    r = data[95:64];
         2'd2:    r = data[63:32];
         default: r = data[31:0];
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/us_timming_flow_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// us_timming_flow_fifo : synchronous show-ahead FIFO, head readable from storage
// Rev 1.0
// ----------------------------------------------------------------------------
module us_timming_flow_fifo #(
   parameter int WIDTH = 130,
   parameter int DEPTH = 16
) (
   input  logic             sys_clk_i,
   input  logic             rst_n_i,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int c_aw = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             w_do_wr;
   logic             w_do_rd;

   assign full    = (r_count == (c_aw+1)'(DEPTH));
   assign empty   = (r_count == '0);
   assign w_do_rd = rd_en && !empty;
   assign w_do_wr = wr_en && (!full || w_do_rd);
   assign dout    = r_mem[r_rd_ptr];

   always_ff @(posedge sys_clk_i) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/us_timming_flow_framer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// us_timming_flow_framer : frames 128-bit timing words into 32-bit beats with
// header, payload and trailer (word count + XOR checksum). Rev 1.0
// ----------------------------------------------------------------------------
module us_timming_flow_framer
   import us_timming_pkg::*;
#(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] SYNC_WORD  = c_sync_word_default,
   parameter logic [15:0] TAIL_WORD  = c_tail_word_default
) (
   input  logic          sys_clk_i,
   input  logic          rst_n_i,
   input  logic          us_timming_flow_vld_i,
   input  logic [127:0]  us_timming_flow_i,
   input  logic          transmit_done_pluse_i,
   output logic [31:0]   m_data_o,
   output logic          m_valid_o,
   output logic          m_last_o,
   input  logic          m_ready_i,
   output logic [15:0]   frame_cnt_o,
   output logic          overflow_o,
   output logic          busy_o
);

   logic                 w_wr_req;
   logic                 w_wr_en;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_xfer;
   logic [c_entry_w-1:0] w_din;
   logic [c_entry_w-1:0] w_head;
   logic                 w_head_eof;
   logic                 w_head_has_data;
   logic [c_data_w-1:0]  w_head_data;

   state_t               r_state;
   logic [1:0]           r_beat;
   logic [15:0]          r_seq;
   logic [15:0]          r_word_cnt;
   logic [31:0]          r_chk;

   assign w_wr_req        = us_timming_flow_vld_i || transmit_done_pluse_i;
   assign w_din           = {transmit_done_pluse_i, us_timming_flow_vld_i, us_timming_flow_i};
   assign w_wr_en         = w_wr_req && (!w_full || w_pop);
   assign w_xfer          = m_valid_o && m_ready_i;
   assign w_head_eof      = w_head[c_eof_bit];
   assign w_head_has_data = w_head[c_has_data_bit];
   assign w_head_data     = w_head[c_data_w-1:0];
   assign busy_o          = (r_state != ST_IDLE) || !w_empty;

   us_timming_flow_fifo #(
      .WIDTH (c_entry_w),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk_i (sys_clk_i),
      .rst_n_i   (rst_n_i),
      .wr_en     (w_wr_en),
      .din       (w_din),
      .full      (w_full),
      .rd_en     (w_pop),
      .dout      (w_head),
      .empty     (w_empty)
   );

   // An entry leaves the FIFO once its last payload beat moves, or when a
   // data-less end-of-frame marker is consumed.
   always_comb begin
      w_pop = 1'b0;
      case (r_state)
         ST_HEAD:    w_pop = w_xfer && !w_head_has_data;
         ST_PAYLOAD: w_pop = w_xfer && (r_beat == c_last_beat);
         ST_NEXT:    w_pop = !w_empty && !w_head_has_data;
         default:    w_pop = 1'b0;
      endcase
   end

   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         overflow_o <= 1'b0;
      end else if (w_wr_req && w_full && !w_pop) begin
         overflow_o <= 1'b1;
      end
   end

   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= ST_IDLE;
         r_beat      <= '0;
         r_seq       <= '0;
         r_word_cnt  <= '0;
         r_chk       <= '0;
         frame_cnt_o <= '0;
         m_valid_o   <= 1'b0;
         m_last_o    <= 1'b0;
         m_data_o    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_word_cnt <= '0;
               r_chk      <= '0;
               if (!w_empty) begin
                  r_state   <= ST_HEAD;
                  m_valid_o <= 1'b1;
                  m_last_o  <= 1'b0;
                  m_data_o  <= {SYNC_WORD, r_seq};
               end
            end
            ST_HEAD: begin
               if (w_xfer) begin
                  if (w_head_has_data) begin
                     r_state  <= ST_PAYLOAD;
                     r_beat   <= '0;
                     m_data_o <= beat_sel(w_head_data, 2'd0);
                  end else begin
                     r_state  <= ST_TAIL0;
                     m_data_o <= {TAIL_WORD, r_word_cnt};
                  end
               end
            end
            ST_PAYLOAD: begin
               if (w_xfer) begin
                  r_chk <= r_chk ^ m_data_o;
                  if (r_beat == c_last_beat) begin
                     r_word_cnt <= r_word_cnt + 16'd1;
                     if (w_head_eof) begin
                        r_state  <= ST_TAIL0;
                        m_data_o <= {TAIL_WORD, r_word_cnt + 16'd1};
                     end else begin
                        r_state   <= ST_NEXT;
                        m_valid_o <= 1'b0;
                     end
                  end else begin
                     r_beat   <= r_beat + 2'd1;
                     m_data_o <= beat_sel(w_head_data, r_beat + 2'd1);
                  end
               end
            end
            ST_NEXT: begin
               if (!w_empty) begin
                  m_valid_o <= 1'b1;
                  if (w_head_has_data) begin
                     r_state  <= ST_PAYLOAD;
                     r_beat   <= '0;
                     m_data_o <= beat_sel(w_head_data, 2'd0);
                  end else begin
                     r_state  <= ST_TAIL0;
                     m_data_o <= {TAIL_WORD, r_word_cnt};
                  end
               end
            end
            ST_TAIL0: begin
               if (w_xfer) begin
                  r_state  <= ST_TAIL1;
                  m_data_o <= r_chk;
                  m_last_o <= 1'b1;
               end
            end
            ST_TAIL1: begin
               if (w_xfer) begin
                  r_state     <= ST_IDLE;
                  m_valid_o   <= 1'b0;
                  m_last_o    <= 1'b0;
                  r_seq       <= r_seq + 16'd1;
                  frame_cnt_o <= frame_cnt_o + 16'd1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               m_valid_o <= 1'b0;
               m_last_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
